beatmap_lane_scheduler: RTL and testbench

//   Sequences and shares the beatmap note generators. Issues a beat-rate step strobe to
//   NUM_LANES lane generators. Round-robin arbitrates their note words onto one

---
 rtl/beatmap_pkg.sv | 16 +
 rtl/beatmap_lane_scheduler_if.sv | 38 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/beatmap_lane_scheduler.sv | 121 ++++++++++++
 tb/tb_beatmap_lane_scheduler.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/beatmap_pkg.sv
// Shared constants and state encoding for the beatmap lane scheduler.
// Defaults match the four-lane, byte-wide, 16-cycle-beat configuration.
package beatmap_pkg;

    localparam int NUM_LANES  = 4;
    localparam int DATA_W     = 8;
    localparam int TICK_DIV   = 16;
    localparam int LANE_IDX_W = $clog2(NUM_LANES);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

endpackage

// File: rtl/beatmap_lane_scheduler_if.sv
// Lane request bus plus the tagged note output stream.
// master = generators/downstream side, slave = scheduler side.
interface beatmap_lane_scheduler_if
    import beatmap_pkg::*;
#(
    parameter int NL = NUM_LANES,
    parameter int DW = DATA_W
) ();

    logic [NL-1:0]         req_valid;
    logic [NL*DW-1:0]      req_data;
    logic [NL-1:0]         req_ready;
    logic                  out_valid;
    logic [DW-1:0]         out_data;
    logic [$clog2(NL)-1:0] out_lane;
    logic                  out_ready;

    modport master (
        output req_valid,
        output req_data,
        output out_ready,
        input  req_ready,
        input  out_valid,
        input  out_data,
        input  out_lane
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  out_ready,
        output req_ready,
        output out_valid,
        output out_data,
        output out_lane
    );

endinterface

// File: rtl/rr_arbiter.sv
// Rotating-priority encoder: first requester at or after ptr_i wins.
// Purely combinational; en_i gates every grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic          en_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] sel;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        sel   = '0;
        for (int k = 0; k < N; k++) begin
            sel = IW'((int'(ptr_i) + k) % N);
            if (en_i && !any_o && req_i[sel]) begin
                any_o      = 1'b1;
                gnt_o[sel] = 1'b1;
                idx_o      = sel;
            end
        end
    end

endmodule

// File: rtl/beatmap_lane_scheduler.sv
// Song control FSM, beat tick, and round-robin merge of lane note words
// into a single registered output slot.
module beatmap_lane_scheduler
    import beatmap_pkg::*;
#(
    parameter int NUM_LANES = beatmap_pkg::NUM_LANES,
    parameter int DATA_W    = beatmap_pkg::DATA_W,
    parameter int TICK_DIV  = beatmap_pkg::TICK_DIV
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 stop,
    output logic [NUM_LANES-1:0] lane_step,
    output logic                 busy,
    output logic [7:0]           beat_cnt,
    beatmap_lane_scheduler_if.slave bus
);

    localparam int IW = $clog2(NUM_LANES);
    localparam int TW = $clog2(TICK_DIV);

    state_e              state_q, state_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [7:0]          beat_q, beat_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic                ov_q, ov_d;
    logic [DATA_W-1:0]   od_q, od_d;
    logic [IW-1:0]       ol_q, ol_d;

    logic [NUM_LANES-1:0] gnt;
    logic [IW-1:0]        gidx;
    logic                 gany;
    logic                 arb_en;
    logic                 tick_wrap;

    // A held word under backpressure blocks any new grant
    assign arb_en    = (state_q != IDLE) && (!ov_q || bus.out_ready);
    assign tick_wrap = (state_q == RUN) && (tick_q == TW'(TICK_DIV - 1));

    rr_arbiter #(.N(NUM_LANES)) u_arb (
        .req_i (bus.req_valid),
        .en_i  (arb_en),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gidx),
        .any_o (gany)
    );

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    tick_d  = '0;
                    beat_d  = '0;
                end
            end
            RUN: begin
                if (stop) state_d = DRAIN;
                if (tick_wrap) begin
                    tick_d = '0;
                    beat_d = beat_q + 8'd1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            DRAIN: begin
                if (bus.req_valid == '0 && !ov_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        ov_d  = ov_q;
        od_d  = od_q;
        ol_d  = ol_q;
        if (gany) begin
            ov_d  = 1'b1;
            od_d  = bus.req_data[gidx*DATA_W +: DATA_W];
            ol_d  = gidx;
            ptr_d = (gidx == IW'(NUM_LANES - 1)) ? '0 : gidx + 1'b1;
        end else if (bus.out_ready) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            tick_q  <= '0;
            beat_q  <= '0;
            ptr_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            ol_q    <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            beat_q  <= beat_d;
            ptr_q   <= ptr_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            ol_q    <= ol_d;
        end
    end

    assign lane_step     = {NUM_LANES{tick_wrap}};
    assign busy          = (state_q != IDLE);
    assign beat_cnt      = beat_q;
    assign bus.req_ready = gnt;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bus.out_lane  = ol_q;

endmodule

// File: tb/tb_beatmap_lane_scheduler.sv
// Directed bench: expected words queued at stimulus time, popped by a
// monitor whenever the output stream handshakes.
module tb_beatmap_lane_scheduler;
    import beatmap_pkg::*;

    logic       clk    = 1'b0;
    logic       resetn = 1'b1;
    logic       start  = 1'b0;
    logic       stop   = 1'b0;
    logic [3:0] lane_step;
    logic       busy;
    logic [7:0] beat_cnt;

    beatmap_lane_scheduler_if bus ();

    beatmap_lane_scheduler dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .stop      (stop),
        .lane_step (lane_step),
        .busy      (busy),
        .beat_cnt  (beat_cnt),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LANE_IDX_W-1:0] lane;
        logic [7:0]            data;
    } word_t;

    int    applied     = 0;
    int    miscompares = 0;
    word_t expq[$];
    word_t e;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int lane);
        word_t w;
        w.lane = LANE_IDX_W'(lane);
        w.data = 8'(160 + 4 * lane);
        expq.push_back(w);
    endtask

    always @(negedge clk) begin
        if (resetn && bus.out_valid && bus.out_ready) begin
            applied++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("FAIL out_word: got lane %0d data %0d, required none",
                         bus.out_lane, bus.out_data);
            end else begin
                e = expq.pop_front();
                if (bus.out_lane !== e.lane || bus.out_data !== e.data) begin
                    miscompares++;
                    $display("FAIL out_word: got lane %0d data %0d, required lane %0d data %0d",
                             bus.out_lane, bus.out_data, e.lane, e.data);
                end
            end
        end
    end

    initial begin
        int pulses;
        int grants;
        int ovs;
        bus.req_valid = '0;
        bus.req_data  = 32'hACA8_A4A0;
        bus.out_ready = 1'b0;
        #1 resetn = 1'b0;

        @(negedge clk);
        chk("rst lane_step", lane_step, 0);
        chk("rst busy", busy, 0);
        chk("rst beat_cnt", beat_cnt, 0);
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst req_ready", bus.req_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) resetn = 1'b1;

        // Idle with requests present: no strobes, no grants
        bus.req_valid = 4'hF;
        bus.out_ready = 1'b1;
        pulses = 0;
        grants = 0;
        ovs    = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (lane_step != 0) pulses++;
            if (bus.req_ready != 0) grants++;
            if (bus.out_valid) ovs++;
        end
        chk("idle lane_step pulses", pulses, 0);
        chk("idle grants", grants, 0);
        chk("idle out_valid", ovs, 0);
        chk("idle busy", busy, 0);
        bus.req_valid = '0;
        bus.out_ready = 1'b0;

        // Beat tick: start pulse in cycle 0
        step();
        start = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            step();
            if (k == 1) start = 1'b0;
            @(negedge clk);
            chk("tick lane_step", lane_step, (k % 16 == 0) ? 4'hF : 4'h0);
            chk("tick beat_cnt", beat_cnt, (k - 1) / 16);
        end
        chk("run busy", busy, 1);

        // Full-throughput round robin
        step();
        bus.out_ready = 1'b1;
        bus.req_valid = 4'hF;
        for (int j = 0; j < 8; j++) push(j % 4);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("rr req_ready", bus.req_ready, 1 << (j % 4));
            step();
        end
        bus.req_valid = '0;
        repeat (2) step();

        // Backpressure hold, then release
        bus.out_ready = 1'b0;
        bus.req_valid = 4'hF;
        push(0);
        push(1);
        @(negedge clk);
        chk("bp first grant", bus.req_ready, 4'b0001);
        for (int j = 1; j <= 5; j++) begin
            step();
            @(negedge clk);
            chk("bp out_valid", bus.out_valid, 1);
            chk("bp out_data", bus.out_data, 160);
            chk("bp out_lane", bus.out_lane, 0);
            chk("bp req_ready", bus.req_ready, 0);
        end
        step();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp release grant", bus.req_ready, 4'b0010);
        step();
        bus.req_valid = '0;
        repeat (2) step();

        // Stop with lanes 1 and 3 pending; pointer is now 2
        bus.req_valid = 4'b1010;
        stop = 1'b1;
        push(3);
        push(1);
        @(negedge clk);
        chk("stop grant", bus.req_ready, 4'b1000);
        step();
        stop = 1'b0;
        bus.req_valid = 4'b0010;
        @(negedge clk);
        chk("drain busy", busy, 1);
        chk("drain lane_step", lane_step, 0);
        chk("drain grant", bus.req_ready, 4'b0010);
        step();
        bus.req_valid = '0;
        @(negedge clk);
        chk("drain busy2", busy, 1);
        chk("drain lane_step2", lane_step, 0);
        step();
        @(negedge clk);
        chk("drain busy3", busy, 1);
        chk("drain out_valid", bus.out_valid, 0);
        step();
        @(negedge clk);
        chk("drain done busy", busy, 0);

        // Async reset mid-transfer
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        bus.out_ready = 1'b0;
        bus.req_valid = 4'hF;
        step();
        bus.req_valid = '0;
        #1;
        chk("pre-reset out_valid", bus.out_valid, 1);
        chk("pre-reset beat_cnt", beat_cnt, 1);
        resetn = 1'b0;
        #1;
        chk("async out_valid", bus.out_valid, 0);
        chk("async busy", busy, 0);
        chk("async beat_cnt", beat_cnt, 0);
        chk("async out_data", bus.out_data, 0);
        @(negedge clk) resetn = 1'b1;

        // Fresh start after reset
        step();
        start = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            if (k == 1) start = 1'b0;
            @(negedge clk);
            if (k == 15) chk("fresh no step", lane_step, 4'h0);
            if (k == 16) chk("fresh step", lane_step, 4'hF);
            if (k == 17) chk("fresh beat_cnt", beat_cnt, 1);
        end
        step();
        bus.out_ready = 1'b1;
        bus.req_valid = 4'hF;
        push(0);
        @(negedge clk);
        chk("fresh ptr grant", bus.req_ready, 4'b0001);
        step();
        bus.req_valid = '0;
        repeat (3) step();

        chk("queue drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
